// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises fetch and load/store traffic onto one SRAM port.
// Define ARB_ROUND_ROBIN_EN to alternate contended grants instead of data-first.
module mem_port_arbiter #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_en,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stallreq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] LAT_INIT = 3'(RD_LAT - 1);

  state_t      state;
  logic [2:0]  cnt;
  logic [31:0] resp_q;
  logic        owner_data;
  logic        ok_inst;
  logic        ok_data;

  logic can_acc;
  logic gnt_inst;
  logic gnt_data;
  logic gnt;
  logic gnt_wr;

  // Held in reset, nothing may be granted even if a req is high.
  assign can_acc = resetn & ((state == IDLE) | (state == RESP));

`ifdef ARB_ROUND_ROBIN_EN
  logic ptr_data;

  assign gnt_data = can_acc & data_req & (~inst_req | ptr_data);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr_data <= 1'b1;
    end else if (gnt & inst_req & data_req) begin
      ptr_data <= ~ptr_data;
    end
  end
`else
  assign gnt_data = can_acc & data_req;
`endif

  assign gnt_inst = can_acc & inst_req & ~gnt_data;
  assign gnt      = gnt_inst | gnt_data;
  assign gnt_wr   = gnt_data & (|data_wen);

  assign inst_addr_ok = gnt_inst;
  assign data_addr_ok = gnt_data;

  assign mem_en    = gnt;
  assign mem_wen   = gnt_data ? data_wen : 4'd0;
  assign mem_wdata = gnt_data ? data_wdata : 32'd0;
  assign mem_addr  = gnt_data ? data_addr :
                     gnt_inst ? inst_addr : 32'd0;

  assign inst_data_ok = ok_inst;
  assign data_data_ok = ok_data;
  assign inst_rdata   = resp_q;
  assign data_rdata   = resp_q;

  assign stallreq = inst_req | data_req | (state != IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      resp_q     <= 32'd0;
      owner_data <= 1'b0;
      ok_inst    <= 1'b0;
      ok_data    <= 1'b0;
    end else begin
      ok_inst <= 1'b0;
      ok_data <= 1'b0;
      unique case (state)
        IDLE, RESP: begin
          if (gnt) begin
            owner_data <= gnt_data;
            if (gnt_wr) begin
              state   <= RESP;
              ok_data <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= LAT_INIT;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            resp_q  <= mem_rdata;
            state   <= RESP;
            ok_inst <= ~owner_data;
            ok_data <= owner_data;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter at RD_LAT 1, 2, 4 and 7.
// Drivers push expected responses; a negedge monitor pops and checks them.
module tb_mem_port_arbiter;

  int checks = 0;
  int failures = 0;
  int ndone = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] rd;
    bit          wr;
  } exp_t;

  function automatic void chk(input string nm, input int lat,
                              input logic [31:0] got,
                              input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s lat=%0d got=%h exp=%h", nm, lat, got, exp);
    end
  endfunction

  function automatic void fail(input string nm, input int lat);
    checks++;
    failures++;
    $display("FAIL %s lat=%0d", nm, lat);
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g
    localparam int L = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 4 : 7;

    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stallreq;

    logic [31:0] sram [64];
    logic [31:0] refm [64];
    logic [31:0] pipe [1:7];
    exp_t        qi[$];
    exp_t        qd[$];
    int          cyc = 0;
    int          last_due = -1;
    bit          ptr_data = 1'b1;
    bit          in_rst = 1'b1;
    logic [31:0] last_rd = 32'd0;

    mem_port_arbiter #(.RD_LAT(L)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .data_req     (data_req),
      .data_wen     (data_wen),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata),
      .mem_en       (mem_en),
      .mem_wen      (mem_wen),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .stallreq     (stallreq)
    );

    function automatic logic [31:0] iv(input int i);
      if (i == 0) return 32'h3C1D_0001;
      return (32'(i) * 32'h9E37_79B9) ^ 32'(gi << 24);
    endfunction

    // SRAM model: word at mem_addr[7:2], data visible L cycles after mem_en.
    assign mem_rdata = pipe[L];

    always @(posedge clk) begin
      if (cyc == 0) begin
        for (int i = 0; i < 64; i++) sram[i] <= iv(i);
      end else if (mem_en && mem_wen != 4'd0) begin
        for (int b = 0; b < 4; b++)
          if (mem_wen[b])
            sram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      for (int k = 7; k >= 2; k--) pipe[k] <= pipe[k-1];
      pipe[1] <= (mem_en && mem_wen == 4'd0) ? sram[mem_addr[7:2]]
                                             : $urandom;
      cyc <= cyc + 1;
    end

    task automatic mon();
      exp_t e;
      bit   acc;
      bit   wd;
      bit   pref;
      chk("both_data_ok", L, {31'd0, inst_data_ok & data_data_ok}, 32'd0);
      if (inst_data_ok) begin
        if (qi.size() == 0) fail("inst_unexpected_data_ok", L);
        else begin
          e = qi.pop_front();
          chk("inst_latency", L, cyc, e.due);
          chk("inst_rdata", L, inst_rdata, e.rd);
          last_rd = e.rd;
        end
      end
      if (data_data_ok) begin
        if (qd.size() == 0) fail("data_unexpected_data_ok", L);
        else begin
          e = qd.pop_front();
          chk("data_latency", L, cyc, e.due);
          if (e.wr) chk("data_rdata_hold", L, data_rdata, last_rd);
          else begin
            chk("data_rdata", L, data_rdata, e.rd);
            last_rd = e.rd;
          end
        end
      end
      if (qi.size() > 0 && qi[0].due < cyc) begin
        fail("inst_data_ok_missing", L);
        void'(qi.pop_front());
      end
      if (qd.size() > 0 && qd[0].due < cyc) begin
        fail("data_data_ok_missing", L);
        void'(qd.pop_front());
      end
      chk("stallreq", L, {31'd0, stallreq},
          {31'd0, inst_req | data_req | (cyc <= last_due)});
      acc = inst_addr_ok | data_addr_ok;
      chk("accept", L, {31'd0, acc},
          {31'd0, (cyc >= last_due) & (inst_req | data_req)});
      chk("mem_en", L, {31'd0, mem_en}, {31'd0, acc});
      if (acc) begin
`ifdef ARB_ROUND_ROBIN_EN
        pref = ptr_data;
`else
        pref = 1'b1;
`endif
        wd = data_req & (~inst_req | pref);
        chk("grant", L, {30'd0, inst_addr_ok, data_addr_ok},
            wd ? 32'd1 : 32'd2);
        if (wd) begin
          chk("mem_addr_d", L, mem_addr, data_addr);
          chk("mem_wen_d", L, {28'd0, mem_wen}, {28'd0, data_wen});
          if (data_wen != 4'd0) chk("mem_wdata", L, mem_wdata, data_wdata);
        end else begin
          chk("mem_addr_i", L, mem_addr, inst_addr);
          chk("mem_wen_i", L, {28'd0, mem_wen}, 32'd0);
        end
        if (inst_req && data_req) ptr_data = ~ptr_data;
        last_due = cyc + ((wd && data_wen != 4'd0) ? 1 : L + 1);
      end else begin
        chk("mem_wen_idle", L, {28'd0, mem_wen}, 32'd0);
      end
    endtask

    always @(negedge clk) begin
      if (in_rst) begin
        qi.delete();
        qd.delete();
        last_due = -1;
        ptr_data = 1'b1;
        last_rd = 32'd0;
      end else begin
        mon();
      end
    end

    function automatic void chk_zero(input string nm);
      chk({nm, "_flags"}, L,
          {26'd0, inst_addr_ok, inst_data_ok, data_addr_ok,
           data_data_ok, mem_en, stallreq}, 32'd0);
      chk({nm, "_mem_wen"}, L, {28'd0, mem_wen}, 32'd0);
      chk({nm, "_mem_addr"}, L, mem_addr, 32'd0);
      chk({nm, "_mem_wdata"}, L, mem_wdata, 32'd0);
      chk({nm, "_inst_rdata"}, L, inst_rdata, 32'd0);
      chk({nm, "_data_rdata"}, L, data_rdata, 32'd0);
    endfunction

    task automatic step();
      bit ia;
      bit da;
      @(negedge clk);
      ia = inst_req & inst_addr_ok;
      da = data_req & data_addr_ok;
      if (ia) qi.push_back('{cyc + L + 1, refm[inst_addr[7:2]], 1'b0});
      if (da) begin
        if (data_wen != 4'd0) begin
          for (int b = 0; b < 4; b++)
            if (data_wen[b])
              refm[data_addr[7:2]][8*b +: 8] = data_wdata[8*b +: 8];
          qd.push_back('{cyc + 1, 32'd0, 1'b1});
        end else begin
          qd.push_back('{cyc + L + 1, refm[data_addr[7:2]], 1'b0});
        end
      end
      @(posedge clk);
      #1;
      if (ia) inst_req = 1'b0;
      if (da) data_req = 1'b0;
    endtask

    task automatic run(input int n, input int pct);
      logic [5:0] ix;
      for (int c = 0; c < n; c++) begin
        if (!inst_req && $urandom_range(99) < pct) begin
          ix = 6'($urandom);
          inst_addr = 32'hBFC0_0000 | {24'd0, ix, 2'b00};
          inst_req = 1'b1;
        end
        if (!data_req && $urandom_range(99) < pct) begin
          ix = 6'($urandom);
          data_addr = 32'h8000_0000 | {24'd0, ix, 2'b00};
          data_wen = ($urandom_range(1) == 1) ? 4'($urandom_range(15, 1))
                                              : 4'd0;
          data_wdata = $urandom;
          data_req = 1'b1;
        end
        step();
      end
    endtask

    task automatic drain();
      int c = 0;
      while ((inst_req || data_req) && c < 100) begin
        step();
        c++;
      end
      if (inst_req || data_req) fail("req_never_granted", L);
      inst_req = 1'b0;
      data_req = 1'b0;
      repeat (L + 3) step();
    endtask

    initial begin
      for (int i = 0; i < 64; i++) refm[i] = iv(i);
      for (int k = 1; k <= 7; k++) pipe[k] = 32'd0;
      resetn = 1'b0;
      inst_req = 1'b0;
      inst_addr = 32'd0;
      data_req = 1'b0;
      data_wen = 4'd0;
      data_addr = 32'd0;
      data_wdata = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_zero("reset");
      @(posedge clk);
      #1;
      resetn = 1'b1;
      in_rst = 1'b0;

      // Boot fetch from the reset vector, then a half-word store.
      inst_addr = 32'hBFC0_0000;
      inst_req = 1'b1;
      drain();
      data_addr = 32'h8000_0010;
      data_wen = 4'b0011;
      data_wdata = 32'h0000_BEEF;
      data_req = 1'b1;
      drain();

      run(300, 45);
      run(300, 100);
      drain();
      chk("queues_empty", L, 32'(qi.size() + qd.size()), 32'd0);

      // Abandon a read in flight with a one-cycle reset pulse.
      data_addr = 32'h8000_0020;
      data_wen = 4'd0;
      data_req = 1'b1;
      @(negedge clk);
      chk("abort_accept", L, {31'd0, data_addr_ok}, 32'd1);
      @(posedge clk);
      #1;
      data_req = 1'b0;
      in_rst = 1'b1;
      resetn = 1'b0;
      @(negedge clk);
      chk("abort_wait", L,
          {29'd0, inst_data_ok, data_data_ok, data_addr_ok}, 32'd0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      @(negedge clk);
      chk_zero("abort_reset");
      in_rst = 1'b0;
      @(posedge clk);
      #1;
      repeat (L + 3) step();

      data_addr = 32'h8000_0020;
      data_wen = 4'd0;
      data_req = 1'b1;
      drain();
      run(80, 60);
      drain();
      chk("queues_empty_end", L, 32'(qi.size() + qd.size()), 32'd0);
      ndone++;
    end
  end

  initial begin
    int t = 0;
    while (ndone < 4 && t < 20000) begin
      @(posedge clk);
      t++;
    end
    if (ndone < 4) fail("timeout", 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
